// File: rtl/ram_wr_pkg.sv
// Shared types and default widths for the port A stream-to-RAM writer.
// Default widths follow the global ADDR_WIDTH/DATA_WIDTH macros when defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package ram_wr_pkg;
    localparam int unsigned DEF_ADDR_WIDTH = `ADDR_WIDTH;
    localparam int unsigned DEF_DATA_WIDTH = `DATA_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_t;
endpackage

// File: rtl/ram_port_a_writer.sv
// Turns a (base, len) command plus a valid/ready beat stream into registered
// port A writes at consecutive, wrapping addresses.
module ram_port_a_writer
    import ram_wr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_a,
    input  logic                  rst_a,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  abort,
    output logic                  we_a,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] data_in_a,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH:0]   beat_cnt
);

    wr_state_t             state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] len_q;
    // One extra bit so a 2^ADDR_WIDTH-beat command can be counted to completion.
    logic [ADDR_WIDTH:0]   idx_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  done_q;
    logic                  aborted_q;

    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] wr_addr;

    assign last_beat = (idx_q == {1'b0, len_q});
    assign wr_addr   = base_q + idx_q[ADDR_WIDTH-1:0];

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == WRITE);
    assign s_ready   = (state_q == WRITE) & ~abort;

    always_ff @(posedge clk_a or negedge rst_a) begin
        if (!rst_a) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        state_q <= WRITE;
                        base_q  <= cmd_base;
                        len_q   <= cmd_len;
                        idx_q   <= '0;
                    end
                end
                WRITE: begin
                    // Abort wins over a simultaneously offered beat.
                    if (abort) begin
                        state_q   <= IDLE;
                        aborted_q <= 1'b1;
                    end else if (s_valid) begin
                        we_q   <= 1'b1;
                        addr_q <= wr_addr;
                        data_q <= s_data;
                        idx_q  <= idx_q + 1'b1;
                        if (last_beat) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign we_a      = we_q;
    assign addr_a    = addr_q;
    assign data_in_a = data_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign beat_cnt  = idx_q;

endmodule

// File: tb/tb_ram_port_a_writer.sv
// Directed and randomized bench for ram_port_a_writer with a behavioural RAM
// on port A and an expected-memory model built from command/beat arithmetic.
module tb_ram_port_a_writer;

    logic       clk_a;
    logic       rst_a;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_base;
    logic [7:0] cmd_len;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       abort;
    logic       we_a;
    logic [7:0] addr_a;
    logic [7:0] data_in_a;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [8:0] beat_cnt;

    int passed;
    int total;

    logic [7:0] ram     [256];
    logic [7:0] exp_mem [256];

    ram_port_a_writer dut (
        .clk_a     (clk_a),
        .rst_a     (rst_a),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .abort     (abort),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .data_in_a (data_in_a),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .beat_cnt  (beat_cnt)
    );

    initial begin
        clk_a = 1'b0;
        forever #5 clk_a = ~clk_a;
    end

    // Port A of the RAM as seen by the consumer's port B.
    always @(posedge clk_a) begin
        if (we_a) ram[addr_a] <= data_in_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Runs one command; called and returns at 1 time unit after a rising edge.
    task automatic do_cmd(input int base, input int len, input int gap_after, input int gap_len,
                          input int abort_after, input bit rand_gaps);
        int  nbeats;
        int  sent;
        int  gaps;
        int  cyc;
        int  budget;
        bit  v;
        bit  ab;
        bit  finished;
        logic [7:0] d;
        int  a;
        nbeats   = len + 1;
        sent     = 0;
        gaps     = 0;
        cyc      = 0;
        finished = 0;
        budget   = 4 * nbeats + 20;
        check("pre_cmd_ready", 32'(cmd_ready), 32'd1);
        check("pre_busy", 32'(busy), 32'd0);
        cmd_valid = 1'b1;
        cmd_base  = 8'(base);
        cmd_len   = 8'(len);
        @(posedge clk_a); #1;
        cmd_valid = 1'b0;
        check("acc_busy", 32'(busy), 32'd1);
        check("acc_cmd_ready", 32'(cmd_ready), 32'd0);
        check("acc_beat_cnt", 32'(beat_cnt), 32'd0);
        while (!finished && cyc < budget) begin
            cyc++;
            ab = (abort_after >= 0) && (sent == abort_after);
            v  = 1'b1;
            if (rand_gaps) v = ($urandom_range(0, 3) != 0);
            else if (gap_after >= 0 && sent == gap_after && gaps < gap_len) begin
                v = 1'b0;
                gaps++;
            end
            if (ab) v = 1'b1;
            d = 8'($urandom);
            s_valid = v;
            s_data  = d;
            abort   = ab;
            #1;
            check("s_ready", 32'(s_ready), ab ? 32'd0 : 32'd1);
            @(posedge clk_a); #1;
            s_valid = 1'b0;
            abort   = 1'b0;
            if (ab) begin
                check("ab_we", 32'(we_a), 32'd0);
                check("ab_pulse", 32'(aborted), 32'd1);
                check("ab_done", 32'(done), 32'd0);
                check("ab_cnt", 32'(beat_cnt), 32'(sent));
                check("ab_cmd_ready", 32'(cmd_ready), 32'd1);
                finished = 1;
            end else if (v) begin
                a = (base + sent) % 256;
                exp_mem[a] = d;
                sent++;
                check("we", 32'(we_a), 32'd1);
                check("addr", 32'(addr_a), 32'(a));
                check("data", 32'(data_in_a), 32'(d));
                check("cnt", 32'(beat_cnt), 32'(sent));
                check("done", 32'(done), (sent == nbeats) ? 32'd1 : 32'd0);
                check("aborted_low", 32'(aborted), 32'd0);
                if (sent == nbeats) begin
                    check("done_busy", 32'(busy), 32'd0);
                    check("done_cmd_ready", 32'(cmd_ready), 32'd1);
                    finished = 1;
                end
            end else begin
                check("gap_we", 32'(we_a), 32'd0);
                check("gap_done", 32'(done), 32'd0);
                check("gap_busy", 32'(busy), 32'd1);
            end
        end
        if (!finished) check("timeout", 32'd1, 32'd0);
        @(posedge clk_a); #1;
        check("post_we", 32'(we_a), 32'd0);
        check("post_done", 32'(done), 32'd0);
        check("post_aborted", 32'(aborted), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_cnt", 32'(beat_cnt), 32'(sent));
        // Read back every address the command touched plus the one after it.
        for (int k = 0; k <= sent && k < 256; k++) begin
            a = (base + k) % 256;
            check($sformatf("rd_%02h", a), 32'(ram[a]), 32'(exp_mem[a]));
        end
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst_a     = 1'b0;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        abort     = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'h00;
            exp_mem[i] = 8'h00;
        end
        #12;
        check("rst_we", 32'(we_a), 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_data", 32'(data_in_a), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_cnt", 32'(beat_cnt), 32'd0);
        @(negedge clk_a);
        rst_a = 1'b1;
        @(posedge clk_a); #1;
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // abort while idle must be ignored
        abort = 1'b1;
        @(posedge clk_a); #1;
        abort = 1'b0;
        check("idle_abort", 32'(aborted), 32'd0);

        do_cmd(8'h10, 3, -1, 0, -1, 1'b0);
        do_cmd(8'hFE, 3, -1, 0, -1, 1'b0);
        do_cmd(8'h20, 4, 2, 2, -1, 1'b0);
        do_cmd(8'h40, 7, -1, 0, 3, 1'b0);
        do_cmd(8'h00, 255, -1, 0, -1, 1'b0);
        for (int r = 0; r < 3; r++)
            do_cmd(int'($urandom_range(0, 255)), int'($urandom_range(0, 31)), -1, 0,
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1, 1'b1);

        // Reset in the middle of a command.
        cmd_valid = 1'b1;
        cmd_base  = 8'h30;
        cmd_len   = 8'd7;
        @(posedge clk_a); #1;
        cmd_valid = 1'b0;
        s_valid   = 1'b1;
        s_data    = 8'h5A;
        @(posedge clk_a); #1;
        s_data    = 8'h5B;
        @(posedge clk_a); #2;
        rst_a = 1'b0;
        #1;
        check("mid_rst_we", 32'(we_a), 32'd0);
        check("mid_rst_addr", 32'(addr_a), 32'd0);
        check("mid_rst_data", 32'(data_in_a), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cnt", 32'(beat_cnt), 32'd0);
        exp_mem[8'h30] = 8'h5A;
        @(negedge clk_a);
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_a); #1;
            check("post_rst_we", 32'(we_a), 32'd0);
        end
        s_valid = 1'b0;
        check("post_rst_ram31", 32'(ram[8'h31]), 32'(exp_mem[8'h31]));
        do_cmd(8'h80, 0, -1, 0, -1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_port_a_writer.md
# ram_port_a_writer

Stream-to-RAM write controller that drives port A of the dual-port RAM. It accepts a write command (base address, beat count), then consumes a valid/ready data stream. Each accepted beat becomes one registered `we_a`/`addr_a`/`data_in_a` write at consecutive, wrapping addresses. Port B stays free for the consumer reading the buffer.

## Interface
- `ADDR_WIDTH`, default 8: RAM address width; must match the RAM instance.
- `DATA_WIDTH`, default 8: RAM data width; must match the RAM instance.

- `clk_a`  in  1: single clock, same clock as RAM port A.
- `rst_a`  in  1: reset, asynchronous, active-low.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: command accepted when both high at a rising edge.
- `cmd_base`  in  ADDR_WIDTH: first write address.
- `cmd_len`  in  ADDR_WIDTH: beat count minus one (0 means 1 beat, all-ones means 2^ADDR_WIDTH beats).
- `s_valid`  in  1: data beat offered.
- `s_ready`  out  1: data beat accepted when both high at a rising edge.
- `s_data`  in  DATA_WIDTH: data beat.
- `abort`  in  1: terminate current command.
- `we_a`  out  1: RAM port A write enable.
- `addr_a`  out  ADDR_WIDTH: RAM port A address.
- `data_in_a`  out  DATA_WIDTH: RAM port A write data.
- `busy`  out  1: command in progress.
- `done`  out  1: one-cycle pulse, last beat written.
- `aborted`  out  1: one-cycle pulse, command terminated by `abort`.
- `beat_cnt`  out  ADDR_WIDTH+1: beats written for the current or last command.

## Operation
- FSM states: IDLE, WRITE.
- IDLE → WRITE on the `cmd_valid & cmd_ready` edge. At that edge:
  - latch base and len;
  - clear the internal index and `beat_cnt`.
- `cmd_ready` = (state == IDLE).
- `s_ready` = (state == WRITE) & ~`abort`. It is combinational from registered state plus `abort`.
- `busy` = (state == WRITE).
- Each accepted beat, registered at the next edge:
  - `we_a` = 1;
  - `addr_a` = (base + index) mod 2^ADDR_WIDTH, wrapping past all-ones to 0;
  - `data_in_a` = `s_data`;
  - index and `beat_cnt` increment.
- Any cycle without an accepted beat registers `we_a` = 0. `addr_a`/`data_in_a` hold their last values.
- Last beat (index == len on acceptance): WRITE → IDLE, and `done` = 1 in the same registered cycle as that beat's `we_a`.
- Abort:
  - `abort` high in WRITE at an edge forces WRITE → IDLE and sets `aborted` = 1 for one cycle.
  - No beat is accepted that cycle; `abort` has priority over `s_valid`.
  - `beat_cnt` holds the count of beats already written.
- `abort` in IDLE is ignored. `cmd_valid` in WRITE is held off (`cmd_ready` = 0).
- Index arithmetic is ADDR_WIDTH+1 bits, so a full 2^ADDR_WIDTH-beat command terminates correctly.

## Timing
- Reset (asynchronous assert, synchronous release), all outputs 0:
  - state = IDLE;
  - `we_a`, `addr_a`, `data_in_a`, `done`, `aborted`, `beat_cnt` = 0;
  - `busy` = 0, `s_ready` = 0, `cmd_ready` = 1 after release.
- Reset mid-command discards the command. No further `we_a` pulses occur.
- Command accept at edge N; first beat can be accepted at edge N+1. That beat's `we_a` is high in cycle N+1..N+2, and the RAM writes at edge N+2.
- Throughput: one beat per cycle with `s_valid` held high. A command of L beats finishes L+1 edges after command accept.
- A new command can be accepted at the edge immediately following the `done` cycle start (`cmd_ready` high in the `done` cycle).
- `s_valid` gaps insert `we_a` = 0 cycles. There is no timeout.

## Structure
- Shared package `ram_wr_pkg`:
  - `typedef enum logic {IDLE, WRITE} wr_state_t`;
  - default width constants tied to `` `ADDR_WIDTH``/`` `DATA_WIDTH``.
- Single flat module; no sub-module.
- Outputs connect directly to the port A interface signals `addr_a`, `data_in_a`, `we_a`.

## Test plan
- Base 0x10, len 3, data 0xA1..0xA4 back-to-back → `we_a` on 4 consecutive cycles at addrs 0x10..0x13; `done` on the 4th; `beat_cnt` = 4; RAM port B reads back 0xA1..0xA4.
- Base 0xFE, len 3 → writes at 0xFE, 0xFF, 0x00, 0x01 (wrap); `done` after 4 beats.
- Base 0x20, len 4, `s_valid` low for 2 cycles after beat 2 → `we_a` gap of 2 cycles; addresses still 0x20..0x24; `done` on the 5th write.
- Base 0x40, len 7, `abort` asserted with `s_valid` high after 3 beats → 3 writes only; no write to 0x43; `aborted` pulse; `beat_cnt` = 3; `cmd_ready` = 1 next cycle.
- Base 0x00, len 0xFF (256 beats) → 256 writes, addr 0x00..0xFF; `done` on last; `beat_cnt` = 256.
- `rst_a` driven low during a command at beat 2 → all outputs 0 immediately; after release, a new command base 0x80, len 0 → single write to 0x80, `done`.
